acc_stream: RTL and testbench
=============================

ACC_STREAM -- requirements
Module: acc_stream

Interface
REQ-001 SHALL have parameter SIZE, default 32, width of operands, accumulator and SUM.
REQ-002 SHALL have parameter CNTW, default 8, width of LEN, internal term counter and CARRY_CNT.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port START  input  1  begin a new accumulation; sampled only in IDLE.
REQ-006 SHALL have port LEN  input  CNTW  number of terms to accumulate; sampled with START.
REQ-007 SHALL have port IN_VALID  input  1  IN_DATA holds a valid term.
REQ-008 SHALL have port IN_READY  output  1  block accepts a term this cycle.
REQ-009 SHALL have port IN_DATA  input  SIZE  unsigned term.
REQ-010 SHALL have port OUT_VALID  output  1  SUM and CARRY_CNT are valid.
REQ-011 SHALL have port OUT_READY  input  1  consumer accepts the result.
REQ-012 SHALL have port SUM  output  SIZE  accumulated sum modulo 2^SIZE.
REQ-013 SHALL have port CARRY_CNT  output  CNTW  number of adder carry-outs during the run.
REQ-014 SHALL have port BUSY  output  1  high in ACC and DONE states.

Function
REQ-015 SHALL compute ACC+IN_DATA with one SIZE-bit instance of the team's RCA ripple-carry adder, CIN tied 0, COUT used as carry flag.
REQ-016 SHALL implement FSM with states IDLE, ACC, DONE.
REQ-017 IDLE: IN_READY=0, OUT_VALID=0, BUSY=0; START=1 with LEN!=0 -> ACC, accumulator<=0, CARRY_CNT<=0, remaining<=LEN.
REQ-018 IDLE: START=1 with LEN=0 -> DONE directly with accumulator<=0, CARRY_CNT<=0.
REQ-019 ACC: IN_READY=1 combinationally; a term is accepted only on cycle with IN_VALID=1 and IN_READY=1.
REQ-020 On accept: accumulator<=adder S, remaining<=remaining-1, CARRY_CNT<=CARRY_CNT+COUT, saturating at 2^CNTW-1.
REQ-021 On accept with remaining==1 -> DONE; OUT_VALID SHALL rise the cycle after the last accepted term (latency 1).
REQ-022 ACC with IN_VALID=0: all state held, no term counted.
REQ-023 DONE: OUT_VALID=1, IN_READY=0; SUM and CARRY_CNT held stable until OUT_VALID and OUT_READY both high.
REQ-024 DONE with OUT_READY=1 -> IDLE next cycle; OUT_VALID deasserts that cycle.
REQ-025 START SHALL be ignored in ACC and DONE; a new run needs START in IDLE, earliest the cycle after the handshake.
REQ-026 SUM SHALL equal the accumulator register at all times (registered output, no combinational path from IN_DATA).
REQ-027 Accumulation wraps modulo 2^SIZE; each wrap counted once in CARRY_CNT.

Reset
REQ-028 RST=1 at a clock edge SHALL force IDLE, accumulator=0, remaining=0, CARRY_CNT=0, so SUM=0, OUT_VALID=0, IN_READY=0, BUSY=0.
REQ-029 RST SHALL have priority over START, IN_VALID and OUT_READY in the same cycle.
REQ-030 RST in ACC or DONE SHALL abort the run; no partial result is presented afterwards.

Verification
REQ-031 LEN=3, terms 5,7,9 back-to-back -> OUT_VALID one cycle after third accept, SUM=21, CARRY_CNT=0.
REQ-032 SIZE=32, LEN=2, terms 0xFFFFFFFF, 0x00000002 -> SUM=0x00000001, CARRY_CNT=1.
REQ-033 LEN=4, IN_VALID toggled 1,0,1,0,1,1 with terms of 1 -> SUM=4, only valid cycles counted, OUT_VALID after 4th accept.
REQ-034 Result with OUT_READY held 0 for 5 cycles -> SUM/CARRY_CNT/OUT_VALID stable; START pulses ignored; IDLE one cycle after OUT_READY=1.
REQ-035 START with LEN=0 -> OUT_VALID next cycle, SUM=0, CARRY_CNT=0.
REQ-036 RST=1 after second of LEN=5 terms -> next cycle all outputs 0, IDLE; new run LEN=1 term 10 yields SUM=10.

Source files
------------

// File: rtl/acc_stream.sv
// acc_stream: streaming accumulator that sums LEN unsigned terms through a
// ripple-carry adder and counts adder carry-outs (saturating).
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   START, LEN          begin a run of LEN terms (sampled only in IDLE)
//   IN_VALID/IN_READY   term handshake, IN_DATA is the term
//   OUT_VALID/OUT_READY result handshake, SUM and CARRY_CNT are the result
//   BUSY                high while a run is accumulating or awaiting hand-off

// rca: N-bit ripple-carry adder built from a chain of full adders.
module rca #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] c;
    assign c[0] = cin;
    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_fa
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate
    assign cout = c[N];
endmodule

module acc_stream #(
    parameter int SIZE = 32,
    parameter int CNTW = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [CNTW-1:0] LEN,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [SIZE-1:0] IN_DATA,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [SIZE-1:0] SUM,
    output logic [CNTW-1:0] CARRY_CNT,
    output logic            BUSY
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t          state_q, state_d;
    logic [SIZE-1:0] acc_q, acc_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] add_s;
    logic            add_cout;
    logic            accept;

    rca #(.N(SIZE)) u_rca (
        .a   (acc_q),
        .b   (IN_DATA),
        .cin (1'b0),
        .s   (add_s),
        .cout(add_cout)
    );

    assign IN_READY  = (state_q == ACC);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q != IDLE);
    assign SUM       = acc_q;
    assign CARRY_CNT = cnt_q;
    assign accept    = IN_VALID && IN_READY;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && START) begin
            acc_d   = '0;
            cnt_d   = '0;
            rem_d   = LEN;
            state_d = (LEN == '0) ? DONE : ACC;
        end else if (accept) begin
            acc_d   = add_s;
            rem_d   = rem_q - CNTW'(1);
            // carry counter sticks at all-ones instead of wrapping
            cnt_d   = (add_cout && cnt_q != '1) ? cnt_q + CNTW'(1) : cnt_q;
            state_d = (rem_q == CNTW'(1)) ? DONE : ACC;
        end else if (state_q == DONE && OUT_READY) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_acc_stream.sv
// tb_acc_stream: directed scoreboard bench for acc_stream.
module tb_acc_stream;
    logic        clk = 0;
    logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  len, carry_cnt;
    logic [31:0] in_data, sum;
    int          tests = 0, fails = 0;
    logic [39:0] exp_q[$];

    acc_stream dut (
        .CLK(clk), .RST(rst), .START(start), .LEN(len),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .SUM(sum), .CARRY_CNT(carry_cnt), .BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pop and compare on every result handshake
    initial forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got sum %0h carry %0h, expected none", sum, carry_cnt);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("sb_sum", sum, e[39:8]);
                chk("sb_carry", {24'd0, carry_cnt}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] n);
        start = 1;
        len   = n;
        tick();
        start = 0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic send(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        tick();
        in_valid = 0;
    endtask

    task automatic finish_run(input string name);
        chk({name, "_ov"}, {31'd0, out_valid}, 32'd1);
        tick();
        chk({name, "_idle_ov"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1; start = 0; len = 0; in_valid = 0; in_data = 0; out_ready = 1;
        tick();
        tick();
        chk("rst_sum", sum, 0);
        chk("rst_carry", {24'd0, carry_cnt}, 0);
        chk("rst_ov", {31'd0, out_valid}, 0);
        chk("rst_ir", {31'd0, in_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst = 0;
        tick();

        // 5+7+9
        exp_q.push_back({32'd21, 8'd0});
        go(3);
        chk("acc_ir", {31'd0, in_ready}, 1);
        send(1, 5);
        send(1, 7);
        chk("basic_ov_early", {31'd0, out_valid}, 0);
        send(1, 9);
        finish_run("basic");

        // single wrap
        exp_q.push_back({32'h1, 8'd1});
        go(2);
        send(1, 32'hFFFF_FFFF);
        send(1, 32'h2);
        finish_run("wrap");

        // gapped valid
        exp_q.push_back({32'd4, 8'd0});
        go(4);
        send(1, 1);
        send(0, 1);
        send(1, 1);
        send(0, 1);
        send(1, 1);
        chk("gap_ov_early", {31'd0, out_valid}, 0);
        chk("gap_sum_mid", sum, 3);
        send(1, 1);
        finish_run("gap");

        // back-pressure with ignored START pulses
        out_ready = 0;
        exp_q.push_back({32'd7, 8'd0});
        go(2);
        send(1, 3);
        send(1, 4);
        for (int k = 0; k < 5; k++) begin
            start = 1;
            len   = 1;
            chk("hold_ov", {31'd0, out_valid}, 1);
            chk("hold_sum", sum, 7);
            chk("hold_carry", {24'd0, carry_cnt}, 0);
            tick();
        end
        start = 0;
        chk("hold_ov_last", {31'd0, out_valid}, 1);
        out_ready = 1;
        tick();
        chk("hold_release_ov", {31'd0, out_valid}, 0);
        chk("hold_release_busy", {31'd0, busy}, 0);

        // two wraps
        exp_q.push_back({32'hFFFF_FFFD, 8'd2});
        go(3);
        send(1, 32'hFFFF_FFFF);
        send(1, 32'hFFFF_FFFF);
        send(1, 32'hFFFF_FFFF);
        finish_run("wrap2");

        // zero length
        exp_q.push_back({32'd0, 8'd0});
        go(0);
        chk("zero_ir", {31'd0, in_ready}, 0);
        finish_run("zero");

        // abort by reset
        go(5);
        send(1, 1);
        send(1, 2);
        rst = 1;
        tick();
        rst = 0;
        chk("abort_sum", sum, 0);
        chk("abort_carry", {24'd0, carry_cnt}, 0);
        chk("abort_ov", {31'd0, out_valid}, 0);
        chk("abort_ir", {31'd0, in_ready}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        exp_q.push_back({32'd10, 8'd0});
        go(1);
        send(1, 10);
        finish_run("after_abort");

        tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
